// File: rtl/lfsr_pkg.sv
// Shared definitions for the parallel LFSR stream generator.
//   lfsr_state_e : controller states (IDLE, FILL, RUN, SKIP)
//   lfsr_step    : one serial LFSR step on a LFSR_MAX_N-wide container;
//                  returns {output bit, next state}. Callers zero-extend
//                  state and taps, so the bits above n stay zero.
package lfsr_pkg;

  // Widest LFSR the step helper supports; N must not exceed this.
  localparam int unsigned LFSR_MAX_N = 64;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RUN,
    SKIP
  } lfsr_state_e;

  function automatic logic [LFSR_MAX_N:0] lfsr_step(
    input logic [LFSR_MAX_N-1:0] s,
    input logic [LFSR_MAX_N-1:0] taps,
    input int unsigned           n
  );
    logic                  fb;
    logic [LFSR_MAX_N-1:0] nxt;
    fb  = ^(s & taps);
    // Shift right and insert the feedback bit at position n-1.
    nxt = (s >> 1) | (LFSR_MAX_N'(fb) << (n - 1));
    return {s[0], nxt};
  endfunction

endpackage

// File: rtl/lfsr_advance.sv
// Combinational DATA_W-step unroll of the serial LFSR.
//   state      : current LFSR state (next unissued bit is state[0])
//   taps       : feedback tap mask
//   word       : DATA_W sequence bits, bit 0 = earliest
//   next_state : state after DATA_W steps
module lfsr_advance
  import lfsr_pkg::*;
#(
  parameter int unsigned N      = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic [N-1:0]      state,
  input  logic [N-1:0]      taps,
  output logic [DATA_W-1:0] word,
  output logic [N-1:0]      next_state
);

  always_comb begin : unroll
    logic [LFSR_MAX_N-1:0] s;
    logic [LFSR_MAX_N-1:0] t;
    logic [LFSR_MAX_N:0]   r;
    word = '0;
    s    = LFSR_MAX_N'(state);
    t    = LFSR_MAX_N'(taps);
    r    = '0;
    for (int unsigned k = 0; k < DATA_W; k++) begin
      r    = lfsr_step(s, t, N);
      word = word | (DATA_W'(r[LFSR_MAX_N]) << k);
      s    = r[LFSR_MAX_N-1:0];
    end
    next_state = s[N-1:0];
  end

endmodule

// File: rtl/lfsr_stream.sv
// Parallel LFSR sequence generator on a valid/ready stream.
//   clk_i, reset_i        : clock, synchronous active-high reset
//   cfg_load_i            : load cfg_taps_i / cfg_seed_i (VARIABLE_CONFIG=1)
//   cfg_taps_i/cfg_seed_i : runtime tap mask and seed
//   cfg_err_o             : one-cycle pulse when a zero seed is rejected
//   skip_i/skip_words_i   : discard skip_words_i words (honoured in RUN)
//   out_data_o            : DATA_W sequence bits, bit 0 = earliest
//   out_valid_o/ready_i   : stream handshake; stall holds word and state
//   busy_o                : high while skipping
module lfsr_stream
  import lfsr_pkg::*;
#(
  parameter int unsigned   N               = 8,
  parameter int unsigned   DATA_W          = 8,
  parameter logic [N-1:0]  START_VALUE     = N'(8'h01),
  parameter logic [N-1:0]  TAPS            = N'(8'h03),
  parameter int unsigned   VARIABLE_CONFIG = 0,
  parameter int unsigned   SKIP_W          = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              cfg_load_i,
  input  logic [N-1:0]      cfg_taps_i,
  input  logic [N-1:0]      cfg_seed_i,
  output logic              cfg_err_o,
  input  logic              skip_i,
  input  logic [SKIP_W-1:0] skip_words_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              busy_o
);

  lfsr_state_e       fsm_q;
  logic [N-1:0]      lfsr_q;   // start of the next unissued word
  logic [N-1:0]      taps_q;
  logic [SKIP_W-1:0] cnt_q;
  logic [DATA_W-1:0] adv_word;
  logic [N-1:0]      adv_next;
  logic              load_ok;
  logic              load_bad;

  lfsr_advance #(
    .N      (N),
    .DATA_W (DATA_W)
  ) u_advance (
    .state      (lfsr_q),
    .taps       (taps_q),
    .word       (adv_word),
    .next_state (adv_next)
  );

  assign load_ok  = (VARIABLE_CONFIG != 0) && cfg_load_i && (cfg_seed_i != '0);
  assign load_bad = (VARIABLE_CONFIG != 0) && cfg_load_i && (cfg_seed_i == '0);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      out_data_o  <= '0;
      out_valid_o <= 1'b0;
      busy_o      <= 1'b0;
      cfg_err_o   <= 1'b0;
      cnt_q       <= '0;
      if (VARIABLE_CONFIG != 0) begin
        lfsr_q <= '0;
        taps_q <= '0;
        fsm_q  <= IDLE;
      end else begin
        lfsr_q <= START_VALUE;
        taps_q <= TAPS;
        fsm_q  <= FILL;
      end
    end else begin
      cfg_err_o <= 1'b0;
      if (load_ok) begin
        taps_q      <= cfg_taps_i;
        lfsr_q      <= cfg_seed_i;
        out_valid_o <= 1'b0;
        busy_o      <= 1'b0;
        cnt_q       <= '0;
        fsm_q       <= FILL;
      end else begin
        // A rejected load only flags the error; the stream carries on.
        if (load_bad) begin
          cfg_err_o <= 1'b1;
        end
        unique case (fsm_q)
          IDLE: ;
          FILL: begin
            out_data_o  <= adv_word;
            lfsr_q      <= adv_next;
            out_valid_o <= 1'b1;
            fsm_q       <= RUN;
          end
          RUN: begin
            // The held word is dropped; lfsr_q already points past it,
            // so skipping counts from the next unissued word.
            if (skip_i) begin
              out_valid_o <= 1'b0;
              if (skip_words_i == '0) begin
                fsm_q <= FILL;
              end else begin
                cnt_q  <= skip_words_i;
                busy_o <= 1'b1;
                fsm_q  <= SKIP;
              end
            end else if (out_valid_o && out_ready_i) begin
              out_data_o <= adv_word;
              lfsr_q     <= adv_next;
            end
          end
          SKIP: begin
            lfsr_q <= adv_next;
            cnt_q  <= cnt_q - SKIP_W'(1);
            if (cnt_q == SKIP_W'(1)) begin
              busy_o <= 1'b0;
              fsm_q  <= FILL;
            end
          end
          default: fsm_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lfsr_stream.sv
module tb_lfsr_stream;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1, cfg_load = 1'b0, skip = 1'b0, ready = 1'b1;
  logic [7:0]  cfg_taps = '0, cfg_seed = '0;
  logic [15:0] skip_words = '0;

  logic [7:0]  d0, d2;
  logic [0:0]  d1;
  logic [2:0]  v, b, e;

  int checks = 0, failures = 0;
  bit chk_en = 1'b0;

  // Instance 0: fixed, 8 bits/word. 1: fixed, 1 bit/word. 2: runtime config.
  lfsr_stream #(.N(8), .DATA_W(8), .START_VALUE(8'h01), .TAPS(8'h03),
                .VARIABLE_CONFIG(0), .SKIP_W(16)) u_fix (
    .clk_i(clk), .reset_i(reset), .cfg_load_i(cfg_load), .cfg_taps_i(cfg_taps),
    .cfg_seed_i(cfg_seed), .cfg_err_o(e[0]), .skip_i(skip), .skip_words_i(skip_words),
    .out_data_o(d0), .out_valid_o(v[0]), .out_ready_i(ready), .busy_o(b[0]));

  lfsr_stream #(.N(8), .DATA_W(1), .START_VALUE(8'h01), .TAPS(8'h03),
                .VARIABLE_CONFIG(0), .SKIP_W(16)) u_bit (
    .clk_i(clk), .reset_i(reset), .cfg_load_i(cfg_load), .cfg_taps_i(cfg_taps),
    .cfg_seed_i(cfg_seed), .cfg_err_o(e[1]), .skip_i(skip), .skip_words_i(skip_words),
    .out_data_o(d1), .out_valid_o(v[1]), .out_ready_i(ready), .busy_o(b[1]));

  lfsr_stream #(.N(8), .DATA_W(8), .START_VALUE(8'h01), .TAPS(8'h03),
                .VARIABLE_CONFIG(1), .SKIP_W(16)) u_var (
    .clk_i(clk), .reset_i(reset), .cfg_load_i(cfg_load), .cfg_taps_i(cfg_taps),
    .cfg_seed_i(cfg_seed), .cfg_err_o(e[2]), .skip_i(skip), .skip_words_i(skip_words),
    .out_data_o(d2), .out_valid_o(v[2]), .out_ready_i(ready), .busy_o(b[2]));

  // ---------------- reference model ----------------
  int          m_dw[3]  = '{8, 1, 8};
  bit          m_var[3] = '{1'b0, 1'b0, 1'b1};
  logic [7:0]  m_s[3], m_t[3];
  logic [63:0] m_data[3];
  bit          m_valid[3], m_busy[3], m_err[3], m_refill[3];
  int          m_left[3];
  logic [63:0] acc0[$];
  logic [63:0] acc1[$];

  // Bits [start, start+cnt) of the serial sequence from seed/taps.
  function automatic logic [63:0] ref_bits(input logic [7:0] seed, input logic [7:0] taps,
                                           input int start, input int cnt);
    logic [7:0]  s;
    logic [63:0] r;
    s = seed;
    r = '0;
    for (int i = 0; i < start + cnt; i++) begin
      if (i >= start) r[i-start] = s[0];
      s = {^(s & taps), s[7:1]};
    end
    return r;
  endfunction

  task automatic gen_word(input int i, output logic [63:0] w);
    w = '0;
    for (int k = 0; k < m_dw[i]; k++) begin
      w[k]   = m_s[i][0];
      m_s[i] = {^(m_s[i] & m_t[i]), m_s[i][7:1]};
    end
  endtask

  task automatic record(input int i, input logic [63:0] w);
    if (i == 0) acc0.push_back(w);
    if (i == 1) acc1.push_back(w);
  endtask

  task automatic model_step(input int i);
    logic [63:0] w;
    if (reset) begin
      m_valid[i] = 1'b0; m_data[i] = '0; m_busy[i] = 1'b0; m_err[i] = 1'b0; m_left[i] = 0;
      if (m_var[i]) begin m_s[i] = '0; m_t[i] = '0; m_refill[i] = 1'b0; end
      else begin m_s[i] = 8'h01; m_t[i] = 8'h03; m_refill[i] = 1'b1; end
      if (i == 0) acc0.delete();
      if (i == 1) acc1.delete();
    end else begin
      m_err[i] = 1'b0;
      if (m_var[i] && cfg_load && cfg_seed != 0) begin
        m_t[i] = cfg_taps; m_s[i] = cfg_seed; m_valid[i] = 1'b0;
        m_busy[i] = 1'b0; m_left[i] = 0; m_refill[i] = 1'b1;
      end else begin
        if (m_var[i] && cfg_load) m_err[i] = 1'b1;
        if (m_refill[i]) begin
          gen_word(i, w); m_data[i] = w; m_valid[i] = 1'b1; m_refill[i] = 1'b0;
        end else if (m_busy[i]) begin
          gen_word(i, w);
          m_left[i]--;
          if (m_left[i] == 0) begin m_busy[i] = 1'b0; m_refill[i] = 1'b1; end
        end else if (m_valid[i]) begin
          if (skip) begin
            if (ready) record(i, m_data[i]);
            m_valid[i] = 1'b0;
            if (skip_words == 0) m_refill[i] = 1'b1;
            else begin m_busy[i] = 1'b1; m_left[i] = int'(skip_words); end
          end else if (ready) begin
            record(i, m_data[i]);
            gen_word(i, w); m_data[i] = w;
          end
        end
      end
    end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) model_step(i);
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] dut_data(input int i);
    case (i)
      0: return 64'(d0);
      1: return 64'(d1);
      default: return 64'(d2);
    endcase
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("valid[%0d]", i), 64'(v[i]), 64'(m_valid[i]));
        chk($sformatf("busy[%0d]", i),  64'(b[i]), 64'(m_busy[i]));
        chk($sformatf("err[%0d]", i),   64'(e[i]), 64'(m_err[i]));
        if (m_valid[i]) chk($sformatf("data[%0d]", i), dut_data(i), m_data[i]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int nb;
    int c;

    // Fixed-mode start-up with full throughput.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    reset  = 1'b0;
    @(negedge clk);
    chk("first_word", 64'(d0), 64'h01);
    chk("first_valid", 64'(v[0]), 64'h1);
    chk("first_bit", 64'(d1), 64'h1);
    @(negedge clk);
    chk("second_word", 64'(d0), 64'h81);
    chk("second_bit", 64'(d1), 64'h0);

    // Backpressure: accepted words must be the gapless reference sequence.
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    for (int k = 0; k < 110; k++) begin
      @(negedge clk);
      ready = (k < 4) ? pat[k] : ($urandom_range(0, 4) != 0);
    end
    @(negedge clk);
    ready = 1'b1;
    chk("words_accepted_ge8", 64'(acc0.size() >= 8), 64'h1);
    chk("bits_accepted_ge64", 64'(acc1.size() >= 64), 64'h1);
    for (int j = 0; j < 16 && j < acc0.size(); j++)
      chk($sformatf("accepted_word%0d", j), acc0[j], ref_bits(8'h01, 8'h03, 8 * j, 8));
    for (int j = 0; j < 64 && j < acc1.size(); j++)
      chk($sformatf("serial_bit%0d", j), acc1[j], ref_bits(8'h01, 8'h03, j, 1));

    // Skip 3 words while the first word is held (not consumed).
    @(negedge clk); reset = 1'b1; ready = 1'b0;
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    skip = 1'b1; skip_words = 16'd3;
    @(negedge clk);
    skip = 1'b0;
    nb = 0;
    c  = 0;
    while (!v[0] && c < 20) begin
      if (b[0]) nb++;
      @(negedge clk);
      c++;
    end
    chk("skip_timeout", 64'(v[0]), 64'h1);
    chk("skip_busy_cycles", 64'(nb), 64'd3);
    chk("skip_next_word", 64'(d0), ref_bits(8'h01, 8'h03, 32, 8));
    chk("skip_next_bit", 64'(d1), ref_bits(8'h01, 8'h03, 4, 1));
    ready = 1'b1;

    // Runtime config load, then a rejected zero seed.
    @(negedge clk);
    cfg_load = 1'b1; cfg_taps = 8'h03; cfg_seed = 8'h01;
    @(negedge clk);
    cfg_load = 1'b0;
    @(negedge clk);
    chk("var_first_word", 64'(d2), 64'h01);
    chk("var_first_valid", 64'(v[2]), 64'h1);
    @(negedge clk);
    chk("var_second_word", 64'(d2), 64'h81);
    cfg_load = 1'b1; cfg_seed = 8'h00; cfg_taps = 8'hff;
    @(negedge clk);
    cfg_load = 1'b0;
    chk("cfg_err_pulse", 64'(e[2]), 64'h1);
    chk("zero_seed_word2", 64'(d2), ref_bits(8'h01, 8'h03, 16, 8));
    chk("fixed_no_err", 64'(e[0]), 64'h0);
    @(negedge clk);
    chk("cfg_err_clear", 64'(e[2]), 64'h0);
    chk("zero_seed_word3", 64'(d2), ref_bits(8'h01, 8'h03, 24, 8));

    // Reset in the middle of a skip.
    skip = 1'b1; skip_words = 16'd10;
    @(negedge clk); skip = 1'b0;
    @(negedge clk);
    chk("midskip_busy", 64'(b[0]), 64'h1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_data0", 64'(d0), 64'h0);
    chk("rst_data1", 64'(d1), 64'h0);
    chk("rst_data2", 64'(d2), 64'h0);
    chk("rst_valid", 64'(v), 64'h0);
    chk("rst_busy", 64'(b), 64'h0);
    chk("rst_err", 64'(e), 64'h0);
    @(negedge clk);
    chk("restart_word", 64'(d0), 64'h01);
    chk("restart_valid", 64'(v[0]), 64'h1);

    // Randomised traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      reset      = ($urandom_range(0, 199) == 0);
      cfg_load   = ($urandom_range(0, 29) == 0);
      cfg_seed   = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      cfg_taps   = 8'($urandom);
      skip       = ($urandom_range(0, 19) == 0);
      skip_words = 16'($urandom_range(0, 6));
      ready      = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    chk_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lfsr_stream.md
Name: lfsr_stream

Overview:
Parametrised successor to the serial LFSR.
- Produces DATA_W sequence bits per clock as a parallel word on a valid/ready stream; backpressure stalls the generator with no lost bits.
- Adds a runtime config load with zero-seed rejection and a jump-ahead skip of a programmable number of words.
- Sits between config/control logic and scramblers or PRBS test-pattern consumers.

Parameters:
N, 8, LFSR state width (≥2)
DATA_W, 8, output bits per word (1..64)
START_VALUE, 8'h01, reset seed when VARIABLE_CONFIG=0
TAPS, 8'h03, feedback tap mask when VARIABLE_CONFIG=0
VARIABLE_CONFIG, 0, 1 = taps/seed loaded at runtime via cfg_load_i
SKIP_W, 16, width of skip word counter

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous, active-high reset
cfg_load_i  in  1  load cfg_taps_i/cfg_seed_i (ignored if VARIABLE_CONFIG=0)
cfg_taps_i  in  N  feedback tap mask
cfg_seed_i  in  N  initial state
cfg_err_o  out  1  one-cycle pulse: load rejected (seed==0)
skip_i  in  1  request: discard skip_words_i words
skip_words_i  in  SKIP_W  words to discard
out_data_o  out  DATA_W  sequence word, bit 0 = earliest bit
out_valid_o  out  1  word valid
out_ready_i  in  1  consumer accepts word
busy_o  out  1  high in SKIP state

Behaviour:
- Serial step, identical to the existing LFSR:
  - output bit = s[0]
  - fb = XOR over i of (s[i] & taps[i])
  - s_next = {fb, s[N-1:1]}
  - one word = DATA_W consecutive steps, unrolled combinationally; out_data_o[k] = k-th bit.
- Reset (reset_i high at posedge):
  - out_valid_o=0, out_data_o=0, busy_o=0, cfg_err_o=0.
  - VARIABLE_CONFIG=0: state=START_VALUE, taps=TAPS, FSM=FILL.
  - VARIABLE_CONFIG=1: state=0, taps=0, FSM=IDLE.
  - Reset overrides everything, including an in-progress skip.
- FSM states: IDLE, FILL, RUN, SKIP.
  - IDLE: out_valid_o=0. A valid load goes to FILL.
  - FILL: register the first word from the current state, advance the state by DATA_W, set out_valid_o=1, go to RUN. First word is valid one cycle after leaving reset (fixed) or after the load cycle (variable).
  - RUN: on out_valid_o & out_ready_i, register the next word and advance, so the output stays valid every cycle under full throughput. When out_ready_i=0, out_data_o/out_valid_o are held stable and the state does not advance.
  - SKIP: entered from RUN on skip_i.
    - Counter loaded with skip_words_i; out_valid_o=0, busy_o=1.
    - Each cycle: advance the state by DATA_W and decrement the counter.
    - On reaching 0, go to FILL.
    - skip_words_i=0 goes directly to FILL (no-op apart from the refill bubble).
    - The word held in out_data_o at the skip request is discarded and not counted; skipping starts from the next unissued word.
- Config load (VARIABLE_CONFIG=1, any state):
  - cfg_seed_i≠0: latch taps and seed, drop out_valid_o next cycle, abort any skip, go to FILL.
  - cfg_seed_i==0: pulse cfg_err_o for one cycle; state, taps and FSM are unchanged.
- Priority, same cycle: reset > cfg_load_i > skip_i > handshake.
- skip_i outside RUN is ignored.
- A handshake completing in the same cycle as skip_i counts as consumed.
- Taps=0 is legal; the state then shifts to zero after N steps.

Decomposition:
- Package lfsr_pkg:
  - state enum {IDLE, FILL, RUN, SKIP}.
  - function lfsr_step(state, taps) returning {bit, next_state}.
- Sub-module lfsr_advance (parameters N, DATA_W):
  - combinational DATA_W-step unroll.
  - inputs: state, taps.
  - outputs: word, next state.
  - Shared by FILL, RUN and SKIP paths.

Test Plan:
1. Fixed N=8, TAPS=8'h03, START_VALUE=8'h01, DATA_W=8, out_ready_i=1 -> out_data_o=8'h01 then 8'h81, out_valid_o high from first cycle after reset.
2. Same config, out_ready_i toggling 1,0,0,1 -> out_data_o held stable while stalled; accepted word sequence still 8'h01, 8'h81 with no gaps or repeats.
3. Skip: in RUN, skip_i with skip_words_i=3 -> busy_o high 3 cycles, no valid words; next accepted word equals the 5th word of the free-running reference (4 = held word + 3 skipped, all discarded).
4. VARIABLE_CONFIG=1: load taps=8'h03, seed=8'h01 -> stream matches scenario 1. Then load seed=0 -> cfg_err_o one-cycle pulse, stream continues uninterrupted.
5. Reset asserted mid-SKIP -> all outputs 0 next cycle; fixed mode restarts with 8'h01.
6. Bit-serial cross-check: DATA_W=1 vs DATA_W=8, same seed/taps, 64 bits -> concatenated output identical to a serial software model.
